background_update: RTL and testbench

BACKGROUND_UPDATE -- requirements
Module: background_update

---
 rtl/background_update.sv | 155 +++++++++++++++
 tb/tb_background_update.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/background_update.sv
`timescale 1ns/1ps
// background_update: per-pixel running-background update with a foreground mask.
// Two-stage valid/ready pipeline. S1 captures the beat plus |pixel-bg|, the
// direction and the frame-based update enable; S2 makes the foreground
// decision, steps the background toward the pixel and holds the output beat.

// Decision/update datapath for one pixel (purely combinational).
module bgu_calc #(
  parameter int unsigned STEP      = 1,
  parameter int unsigned THRESHOLD = 20
) (
  input  logic [7:0] pixel,
  input  logic [7:0] bg,
  input  logic [7:0] absd,
  input  logic       gt,
  input  logic       upd_en,
  output logic [7:0] bg_new,
  output logic       fg
);
  localparam logic [7:0] STEP_B = STEP[7:0];
  localparam logic [7:0] THR_B  = THRESHOLD[7:0];

  // Strict threshold for fg. A background update never overshoots the pixel,
  // so bg+STEP / bg-STEP only happen when the pixel is more than STEP away and
  // the result therefore always stays within 0..255.
  always_comb begin
    fg     = (absd > THR_B);
    bg_new = bg;
    if (upd_en && !fg) begin
      if (absd <= STEP_B) bg_new = pixel;
      else if (gt)        bg_new = bg + STEP_B;
      else                bg_new = bg - STEP_B;
    end
  end
endmodule

module background_update #(
  parameter int unsigned STEP          = 1,
  parameter int unsigned THRESHOLD     = 20,
  parameter int unsigned UPDATE_PERIOD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_sof,
  input  logic [7:0] s_pixel,
  input  logic [7:0] s_bg,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_sof,
  output logic [7:0] m_bg,
  output logic       m_fg
);
  localparam int         STAGES = 2;
  localparam logic [7:0] PER_M1 = 8'(UPDATE_PERIOD - 1);

  typedef struct packed {
    logic       sof;
    logic [7:0] pixel;
    logic [7:0] bg;
    logic [7:0] absd;
    logic       gt;
    logic       upd_en;
  } s1_t;

  logic [STAGES:1] vld_pipe;
  logic            rdy_en;
  logic            ld2, adv1, s_fire;
  logic [7:0]      frm_cnt, cnt_nxt;
  logic [8:0]      diff;
  logic [7:0]      absd;
  s1_t             s1;
  logic [7:0]      bg_new;
  logic            fg;

  // Handshake: S2 can take a beat when empty or draining; S1 accepts when
  // empty or moving on. rdy_en keeps s_ready low until the first edge after reset.
  assign ld2     = !vld_pipe[2] || m_ready;
  assign adv1    = vld_pipe[1] && ld2;
  assign s_ready = rdy_en && (!vld_pipe[1] || ld2);
  assign s_fire  = s_valid && s_ready;
  assign m_valid = vld_pipe[2];

  // Frame counter value that applies to the current input beat.
  always_comb begin
    cnt_nxt = frm_cnt;
    if (s_sof) cnt_nxt = (frm_cnt == PER_M1) ? 8'd0 : frm_cnt + 8'd1;
  end

  // 9-bit difference so |pixel-bg| never wraps.
  always_comb begin
    diff = {1'b0, s_pixel} - {1'b0, s_bg};
    absd = diff[8] ? 8'(9'd0 - diff) : diff[7:0];
  end

  // Ready enable and frame counter; sof only counts on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en  <= 1'b0;
      frm_cnt <= 8'd0;
    end else begin
      rdy_en <= 1'b1;
      if (s_fire && s_sof) frm_cnt <= cnt_nxt;
    end
  end

  // Valid shift chain with stall: S1 fills on accept, empties when it moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (s_fire)    vld_pipe[1] <= 1'b1;
      else if (adv1) vld_pipe[1] <= 1'b0;
      if (ld2)       vld_pipe[2] <= vld_pipe[1];
    end
  end

  // S1 register: beat plus magnitude, direction and update enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (s_fire) begin
      s1.sof    <= s_sof;
      s1.pixel  <= s_pixel;
      s1.bg     <= s_bg;
      s1.absd   <= absd;
      s1.gt     <= (s_pixel > s_bg);
      s1.upd_en <= (cnt_nxt == 8'd0);
    end
  end

  bgu_calc #(.STEP(STEP), .THRESHOLD(THRESHOLD)) u_calc (
    .pixel  (s1.pixel),
    .bg     (s1.bg),
    .absd   (s1.absd),
    .gt     (s1.gt),
    .upd_en (s1.upd_en),
    .bg_new (bg_new),
    .fg     (fg)
  );

  // S2 output register: loads only when S1 hands over, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sof <= 1'b0;
      m_bg  <= 8'd0;
      m_fg  <= 1'b0;
    end else if (adv1) begin
      m_sof <= s1.sof;
      m_bg  <= bg_new;
      m_fg  <= fg;
    end
  end
endmodule

// File: tb/tb_background_update.sv
`timescale 1ns/1ps
// Directed bench for background_update: two instances share the input stream,
// A with STEP=1/UPDATE_PERIOD=1 and B with STEP=4/UPDATE_PERIOD=3.
module tb_background_update;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b0;
  logic [7:0] s_pixel = 8'd0, s_bg = 8'd0;
  logic       s_ready_a, m_valid_a, m_sof_a, m_fg_a;
  logic       s_ready_b, m_valid_b, m_sof_b, m_fg_b;
  logic [7:0] m_bg_a, m_bg_b;

  always #5 clk = ~clk;

  background_update #(.STEP(1), .THRESHOLD(20), .UPDATE_PERIOD(1)) u_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a), .s_sof(s_sof),
    .s_pixel(s_pixel), .s_bg(s_bg), .m_valid(m_valid_a), .m_ready(m_ready),
    .m_sof(m_sof_a), .m_bg(m_bg_a), .m_fg(m_fg_a));

  background_update #(.STEP(4), .THRESHOLD(20), .UPDATE_PERIOD(3)) u_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_sof(s_sof),
    .s_pixel(s_pixel), .s_bg(s_bg), .m_valid(m_valid_b), .m_ready(m_ready),
    .m_sof(m_sof_b), .m_bg(m_bg_b), .m_fg(m_fg_b));

  typedef struct {
    logic [7:0] pix, bg;
    logic [7:0] bg_a; logic fg_a;
    logic [7:0] bg_b; logic fg_b;
  } vec_t;
  typedef struct packed {
    logic sof; logic [7:0] bg_a; logic fg_a; logic [7:0] bg_b; logic fg_b;
  } obs_t;

  vec_t  vecs[12];
  obs_t  obs_q[$];
  int    n_cmp = 0, n_bad = 0;
  int    cyc = 0;
  logic  hold_p = 1'b0, bp_seen = 1'b0;
  obs_t  hold_v;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Output monitor on the falling edge: log transfers, check stall stability,
  // note backpressure and A/B handshake agreement.
  always @(negedge clk) begin
    obs_t o;
    o = {m_sof_a, m_bg_a, m_fg_a, m_bg_b, m_fg_b};
    if (m_valid_a != m_valid_b || s_ready_a != s_ready_b)
      chk("ab_handshake", {m_valid_b, s_ready_b}, {m_valid_a, s_ready_a});
    if (m_valid_a && m_ready) obs_q.push_back(o);
    if (hold_p && rst_n) begin
      chk("stall_hold_valid", m_valid_a, 1);
      chk("stall_hold_data", int'(o), int'(hold_v));
    end
    if (rst_n && s_valid && !s_ready_a) bp_seen = 1'b1;
    hold_p = rst_n && m_valid_a && !m_ready;
    hold_v = o;
  end

  // Offer one beat; it is accepted on the first edge that sees s_ready.
  task automatic send(input logic [7:0] p, input logic [7:0] b, input logic sof);
    int n = 0;
    s_valid = 1'b1; s_pixel = p; s_bg = b; s_sof = sof;
    @(negedge clk);
    while (!s_ready_a && n < 50) begin @(negedge clk); n++; end
    if (!s_ready_a) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (obs_q.size() < n && k < 40) begin @(posedge clk); k++; end
    #1;
    chk("drain_count", obs_q.size(), n);
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_sof = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    obs_q.delete();
  endtask

  initial begin
    int t0;
    //          pix    bg    bg_a fg_a  bg_b fg_b
    vecs[0]  = '{8'd100, 8'd90,  8'd91,  1'b0, 8'd94,  1'b0};
    vecs[1]  = '{8'd200, 8'd50,  8'd50,  1'b1, 8'd50,  1'b1};
    vecs[2]  = '{8'd3,   8'd4,   8'd3,   1'b0, 8'd3,   1'b0};
    vecs[3]  = '{8'd0,   8'd2,   8'd1,   1'b0, 8'd0,   1'b0};
    vecs[4]  = '{8'd77,  8'd77,  8'd77,  1'b0, 8'd77,  1'b0};
    vecs[5]  = '{8'd255, 8'd250, 8'd251, 1'b0, 8'd254, 1'b0};
    vecs[6]  = '{8'd0,   8'd20,  8'd19,  1'b0, 8'd16,  1'b0};
    vecs[7]  = '{8'd21,  8'd0,   8'd0,   1'b1, 8'd0,   1'b1};
    vecs[8]  = '{8'd255, 8'd235, 8'd236, 1'b0, 8'd239, 1'b0};
    vecs[9]  = '{8'd240, 8'd255, 8'd254, 1'b0, 8'd251, 1'b0};
    vecs[10] = '{8'd5,   8'd1,   8'd2,   1'b0, 8'd5,   1'b0};
    vecs[11] = '{8'd6,   8'd1,   8'd2,   1'b0, 8'd5,   1'b0};

    // Reset state
    #12;
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_s_ready", s_ready_a, 0);
    chk("rst_m_bg", m_bg_b, 0);
    chk("rst_m_fg_sof", {m_fg_a, m_sof_a}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("s_ready_before_edge", s_ready_a, 0);
    @(posedge clk); #1;
    chk("s_ready_after_edge", s_ready_a, 1);

    // Basic latency: accepted at edge N, visible in cycle N+2
    m_ready = 1'b1;
    s_valid = 1'b1; s_pixel = 8'd100; s_bg = 8'd90; s_sof = 1'b0;
    @(posedge clk); #1 s_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1_m_valid", m_valid_a, 0);
    @(negedge clk);
    chk("lat_n2_m_valid", m_valid_a, 1);
    chk("lat_n2_m_bg_a", m_bg_a, 91);
    chk("lat_n2_m_fg_a", m_fg_a, 0);
    chk("lat_n2_m_bg_b", m_bg_b, 94);
    @(posedge clk); #1 obs_q.delete();

    // Table stream, back to back with m_ready high
    t0 = cyc;
    for (int i = 0; i < 12; i++) send(vecs[i].pix, vecs[i].bg, 1'b0);
    chk("throughput_cycles", cyc - t0, 12);
    drain(12);
    for (int i = 0; i < 12 && i < obs_q.size(); i++) begin
      chk($sformatf("tbl%0d_bg_a", i), obs_q[i].bg_a, vecs[i].bg_a);
      chk($sformatf("tbl%0d_fg_a", i), obs_q[i].fg_a, vecs[i].fg_a);
      chk($sformatf("tbl%0d_bg_b", i), obs_q[i].bg_b, vecs[i].bg_b);
      chk($sformatf("tbl%0d_fg_b", i), obs_q[i].fg_b, vecs[i].fg_b);
    end
    obs_q.delete();

    // Stall: 8 beats, m_ready low for three cycles mid-stream
    bp_seen = 1'b0;
    fork
      begin for (int i = 0; i < 8; i++) send(vecs[i].pix, vecs[i].bg, 1'b0); end
      begin
        m_ready = 1'b1;
        repeat (3) @(posedge clk); #1 m_ready = 1'b0;
        repeat (3) @(posedge clk); #1 m_ready = 1'b1;
      end
    join
    drain(8);
    chk("stall_backpressure", bp_seen, 1);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      chk($sformatf("stall%0d_bg_a", i), obs_q[i].bg_a, vecs[i].bg_a);
      chk($sformatf("stall%0d_bg_b", i), obs_q[i].bg_b, vecs[i].bg_b);
    end

    // Frame counter, UPDATE_PERIOD=3 on B; sof without valid is ignored
    do_reset();
    s_sof = 1'b1; repeat (3) @(posedge clk); #1 s_sof = 1'b0;
    for (int f = 1; f <= 6; f++)
      for (int j = 0; j < 2; j++) send(8'd100, 8'd90, j == 0);
    drain(12);
    for (int k = 0; k < 12 && k < obs_q.size(); k++) begin
      chk($sformatf("frm%0d_sof", k), obs_q[k].sof, (k % 2) == 0);
      chk($sformatf("frm%0d_bg_a", k), obs_q[k].bg_a, 91);
      chk($sformatf("frm%0d_bg_b", k), obs_q[k].bg_b, ((k / 2 + 1) % 3 == 0) ? 94 : 90);
    end

    // Reset with two beats in flight
    obs_q.delete();
    m_ready = 1'b0;
    send(8'd100, 8'd90, 1'b1);
    send(8'd100, 8'd90, 1'b1);
    chk("inflight_m_valid", m_valid_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_m_valid", m_valid_a, 0);
    chk("async_rst_s_ready", s_ready_a, 0);
    chk("async_rst_outs", {m_sof_a, m_fg_a, m_bg_a}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1; m_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("no_stale_beats", obs_q.size(), 0);
    send(8'd100, 8'd90, 1'b0);
    send(8'd100, 8'd90, 1'b1);
    drain(2);
    if (obs_q.size() >= 2) begin
      chk("post_rst_cnt0_bg_b", obs_q[0].bg_b, 94);
      chk("post_rst_cnt1_bg_b", obs_q[1].bg_b, 90);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
